// File: rtl/spu_pipe_pkg.sv
// Shared types and constants for the SPU result staging pipe and its forwarding selectors.
package spu_pipe_pkg;

  localparam int SPU_ADDR_W = 7;
  localparam int SPU_DATA_W = 128;
  localparam int SPU_LAT_W  = 4;
  localparam int EVEN_PIPE  = 0;
  localparam int ODD_PIPE   = 1;

  typedef struct packed {
    logic                  valid;
    logic                  reg_wr;
    logic [SPU_ADDR_W-1:0] dst;
    logic [SPU_LAT_W-1:0]  lat;
    logic [SPU_DATA_W-1:0] data;
  } result_pkt_t;

endpackage

// File: rtl/spu_fwd_select.sv
// Priority forwarding match for one operand port over the NUM_PIPES x DEPTH stage array.
// Entry e = (stage-1)*NUM_PIPES + pipe; youngest stage wins, higher pipe wins within a stage.
module spu_fwd_select
  import spu_pipe_pkg::*;
#(
  parameter int NUM_PIPES = 2,
  parameter int DEPTH     = 7,
  parameter int DATA_W    = SPU_DATA_W,
  parameter int ADDR_W    = SPU_ADDR_W,
  parameter int LAT_W     = SPU_LAT_W
) (
  input  logic [ADDR_W-1:0]                 addr,
  input  logic [NUM_PIPES*DEPTH-1:0]        ent_vld,
  input  logic [NUM_PIPES*DEPTH*ADDR_W-1:0] ent_dst,
  input  logic [NUM_PIPES*DEPTH*LAT_W-1:0]  ent_lat,
  input  logic [NUM_PIPES*DEPTH*DATA_W-1:0] ent_data,
  output logic                              hit,
  output logic                              pending,
  output logic [DATA_W-1:0]                 data
);

  logic              found;
  logic [LAT_W-1:0]  win_stage;
  logic [LAT_W-1:0]  win_lat;
  logic [DATA_W-1:0] win_data;

  // Walk oldest to youngest so the last match overwriting the winner is the youngest one.
  always_comb begin
    found     = 1'b0;
    win_stage = '0;
    win_lat   = '0;
    win_data  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        if (ent_vld[(k-1)*NUM_PIPES+p] &&
            ent_dst[((k-1)*NUM_PIPES+p)*ADDR_W +: ADDR_W] == addr) begin
          found     = 1'b1;
          win_stage = LAT_W'(k);
          win_lat   = ent_lat[((k-1)*NUM_PIPES+p)*LAT_W +: LAT_W];
          win_data  = ent_data[((k-1)*NUM_PIPES+p)*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign hit     = found && (win_stage >= win_lat);
  assign pending = found && (win_stage < win_lat);
  assign data    = hit ? win_data : '0;

endmodule

// File: rtl/spu_result_pipe.sv
// Multi-channel FU result staging with forwarding, partial flush and RF writeback.
// Optional retire/flush statistics are built only when SPU_PIPE_STATS_EN is defined.
module spu_result_pipe
  import spu_pipe_pkg::*;
#(
  parameter int NUM_PIPES   = 2,
  parameter int DEPTH       = 7,
  parameter int DATA_W      = SPU_DATA_W,
  parameter int ADDR_W      = SPU_ADDR_W,
  parameter int LAT_W       = SPU_LAT_W,
  parameter int NUM_FWD     = 6,
  parameter int FLUSH_DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PIPES-1:0]          issue_valid,
  input  logic [NUM_PIPES-1:0]          issue_reg_wr,
  input  logic [NUM_PIPES*ADDR_W-1:0]   issue_dst,
  input  logic [NUM_PIPES*LAT_W-1:0]    issue_lat,
  input  logic [NUM_PIPES*DATA_W-1:0]   issue_data,
  input  logic                          flush,
  input  logic [NUM_FWD*ADDR_W-1:0]     fwd_addr,
  output logic [NUM_FWD-1:0]            fwd_hit,
  output logic [NUM_FWD-1:0]            fwd_pending,
  output logic [NUM_FWD*DATA_W-1:0]     fwd_data,
  output logic [NUM_PIPES-1:0]          wb_en,
  output logic [NUM_PIPES*ADDR_W-1:0]   wb_addr,
  output logic [NUM_PIPES*DATA_W-1:0]   wb_data,
  output logic                          lat_err,
  output logic [NUM_PIPES*32-1:0]       stat_retired,
  output logic [31:0]                   stat_flushed
);

  localparam int NE = NUM_PIPES * DEPTH;
  localparam int NK = FLUSH_DEPTH * NUM_PIPES;
  localparam int WB = (DEPTH - 1) * NUM_PIPES;

  function automatic logic [LAT_W-1:0] lat_norm(input logic [LAT_W-1:0] l);
    if (l == '0) return LAT_W'(1);
    if (l > LAT_W'(DEPTH)) return LAT_W'(DEPTH);
    return l;
  endfunction

  // Entry e = (stage-1)*NUM_PIPES + pipe, so one shift by NUM_PIPES advances every stage.
  logic [NE-1:0]        vld_q;
  logic [NE-1:0]        wr_q;
  logic [NE*ADDR_W-1:0] dst_q;
  logic [NE*LAT_W-1:0]  lat_q;
  logic [NE*DATA_W-1:0] data_q;

  logic [NUM_PIPES-1:0]       iss_vld_p0;
  logic [NUM_PIPES*LAT_W-1:0] iss_lat_p0;
  logic                       lat_bad_p0;
  logic [NE-NUM_PIPES-1:0]    adv_vld;

  always_comb begin
    iss_vld_p0 = issue_valid & ~{NUM_PIPES{flush}};
    iss_lat_p0 = '0;
    lat_bad_p0 = 1'b0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      iss_lat_p0[p*LAT_W +: LAT_W] = lat_norm(issue_lat[p*LAT_W +: LAT_W]);
      if (issue_valid[p] && (issue_lat[p*LAT_W +: LAT_W] == '0 ||
                             issue_lat[p*LAT_W +: LAT_W] > LAT_W'(DEPTH)))
        lat_bad_p0 = 1'b1;
    end
    adv_vld = vld_q[NE-NUM_PIPES-1:0];
    if (flush) adv_vld[NK-1:0] = '0;
  end

  // ---- stage 1..DEPTH: control (reset) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      lat_err <= 1'b0;
    end else begin
      vld_q <= {adv_vld, iss_vld_p0};
      if (lat_bad_p0) lat_err <= 1'b1;
    end
  end

  // ---- stage 1..DEPTH: payload (no reset) ----
  always_ff @(posedge clk) begin
    wr_q   <= {wr_q[NE-NUM_PIPES-1:0], issue_reg_wr};
    dst_q  <= {dst_q[(NE-NUM_PIPES)*ADDR_W-1:0], issue_dst};
    lat_q  <= {lat_q[(NE-NUM_PIPES)*LAT_W-1:0], iss_lat_p0};
    data_q <= {data_q[(NE-NUM_PIPES)*DATA_W-1:0], issue_data};
  end

  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_wb
    assign wb_en[p]                    = vld_q[WB+p] & wr_q[WB+p];
    assign wb_addr[p*ADDR_W +: ADDR_W] = wb_en[p] ? dst_q[(WB+p)*ADDR_W +: ADDR_W] : '0;
    assign wb_data[p*DATA_W +: DATA_W] = wb_en[p] ? data_q[(WB+p)*DATA_W +: DATA_W] : '0;
  end

  for (genvar f = 0; f < NUM_FWD; f++) begin : g_fwd
    spu_fwd_select #(
      .NUM_PIPES(NUM_PIPES),
      .DEPTH    (DEPTH),
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .LAT_W    (LAT_W)
    ) u_sel (
      .addr    (fwd_addr[f*ADDR_W +: ADDR_W]),
      .ent_vld (vld_q & wr_q),
      .ent_dst (dst_q),
      .ent_lat (lat_q),
      .ent_data(data_q),
      .hit     (fwd_hit[f]),
      .pending (fwd_pending[f]),
      .data    (fwd_data[f*DATA_W +: DATA_W])
    );
  end

`ifdef SPU_PIPE_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [31:0] retired_q [NUM_PIPES];
  logic [31:0] flushed_q;
  logic [31:0] kill_cnt;

  // Killed packets = valid entries in the flushed stages plus the dropped issues.
  always_comb begin
    kill_cnt = '0;
    if (flush) begin
      for (int i = 0; i < NK; i++) kill_cnt = kill_cnt + 32'(vld_q[i]);
      for (int p = 0; p < NUM_PIPES; p++) kill_cnt = kill_cnt + 32'(issue_valid[p]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flushed_q <= '0;
      for (int p = 0; p < NUM_PIPES; p++) retired_q[p] <= '0;
    end else begin
      flushed_q <= sat_add(flushed_q, kill_cnt);
      for (int p = 0; p < NUM_PIPES; p++)
        retired_q[p] <= sat_add(retired_q[p], 32'(vld_q[WB+p]));
    end
  end

  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_stat
    assign stat_retired[p*32 +: 32] = retired_q[p];
  end
  assign stat_flushed = flushed_q;
`else
  assign stat_retired = '0;
  assign stat_flushed = '0;
`endif

endmodule

// File: tb/tb_spu_result_pipe.sv
// Directed bench for spu_result_pipe: in-flight packet list model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_spu_result_pipe;

  localparam int NP = 2;
  localparam int DEPTH = 7;
  localparam int DW = 128;
  localparam int AW = 7;
  localparam int LW = 4;
  localparam int NF = 6;
  localparam int FD = 3;
`ifdef SPU_PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [NP-1:0]     issue_valid;
  logic [NP-1:0]     issue_reg_wr;
  logic [NP*AW-1:0]  issue_dst;
  logic [NP*LW-1:0]  issue_lat;
  logic [NP*DW-1:0]  issue_data;
  logic              flush;
  logic [NF*AW-1:0]  fwd_addr;
  logic [NF-1:0]     fwd_hit;
  logic [NF-1:0]     fwd_pending;
  logic [NF*DW-1:0]  fwd_data;
  logic [NP-1:0]     wb_en;
  logic [NP*AW-1:0]  wb_addr;
  logic [NP*DW-1:0]  wb_data;
  logic              lat_err;
  logic [NP*32-1:0]  stat_retired;
  logic [31:0]       stat_flushed;

  spu_result_pipe dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_reg_wr(issue_reg_wr), .issue_dst(issue_dst),
    .issue_lat(issue_lat), .issue_data(issue_data), .flush(flush),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_pending(fwd_pending), .fwd_data(fwd_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .lat_err(lat_err),
    .stat_retired(stat_retired), .stat_flushed(stat_flushed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          pipe;
    bit          wr;
    int          dst;
    int          lat;
    logic [127:0] data;
    int          stage;
  } mpkt_t;

  mpkt_t inflight[$];
  int    m_ret[NP];
  int    m_flushed;
  bit    m_lat_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    inflight.delete();
    for (int p = 0; p < NP; p++) m_ret[p] = 0;
    m_flushed = 0;
    m_lat_err = 0;
  endfunction

  // Next state of the in-flight list for the edge about to happen, from current inputs.
  function automatic void model_edge();
    mpkt_t nq[$];
    for (int i = 0; i < inflight.size(); i++) begin
      mpkt_t e;
      e = inflight[i];
      if (e.stage == DEPTH) m_ret[e.pipe]++;
      else if (flush && e.stage <= FD) m_flushed++;
      else begin
        e.stage++;
        nq.push_back(e);
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (issue_valid[p]) begin
        int l;
        mpkt_t e;
        l = int'(issue_lat[p*LW +: LW]);
        if (l == 0 || l > DEPTH) m_lat_err = 1;
        if (flush) m_flushed++;
        else begin
          e.pipe = p;
          e.wr = issue_reg_wr[p];
          e.dst = int'(issue_dst[p*AW +: AW]);
          e.lat = (l == 0) ? 1 : (l > DEPTH ? DEPTH : l);
          e.data = issue_data[p*DW +: DW];
          e.stage = 1;
          nq.push_back(e);
        end
      end
    end
    inflight = nq;
  endfunction

  function automatic void exp_fwd(input int addr, output bit hit, output bit pend,
                                  output logic [127:0] data);
    int idx = -1;
    int bs = 0;
    int bp = -1;
    hit = 0; pend = 0; data = '0;
    for (int i = 0; i < inflight.size(); i++) begin
      if (inflight[i].wr && inflight[i].dst == addr) begin
        if (idx < 0 || inflight[i].stage < bs ||
            (inflight[i].stage == bs && inflight[i].pipe > bp)) begin
          idx = i; bs = inflight[i].stage; bp = inflight[i].pipe;
        end
      end
    end
    if (idx >= 0) begin
      if (bs >= inflight[idx].lat) begin
        hit = 1;
        data = inflight[idx].data;
      end else pend = 1;
    end
  endfunction

  task automatic compare_all();
    for (int p = 0; p < NP; p++) begin
      bit en;
      int a;
      logic [127:0] d;
      en = 0; a = 0; d = '0;
      foreach (inflight[i])
        if (inflight[i].pipe == p && inflight[i].stage == DEPTH && inflight[i].wr) begin
          en = 1; a = inflight[i].dst; d = inflight[i].data;
        end
      chk($sformatf("wb_en[%0d]", p), wb_en[p], en);
      if (en) begin
        chk($sformatf("wb_addr[%0d]", p), wb_addr[p*AW +: AW], a);
        chk($sformatf("wb_data[%0d]", p), wb_data[p*DW +: DW], d);
      end
      chk($sformatf("stat_retired[%0d]", p), stat_retired[p*32 +: 32], STATS ? m_ret[p] : 0);
    end
    for (int f = 0; f < NF; f++) begin
      bit h, pd;
      logic [127:0] d;
      exp_fwd(int'(fwd_addr[f*AW +: AW]), h, pd, d);
      chk($sformatf("fwd_hit[%0d]", f), fwd_hit[f], h);
      chk($sformatf("fwd_pending[%0d]", f), fwd_pending[f], pd);
      chk($sformatf("fwd_data[%0d]", f), fwd_data[f*DW +: DW], d);
    end
    chk("lat_err", lat_err, m_lat_err);
    chk("stat_flushed", stat_flushed, STATS ? m_flushed : 0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    issue_valid = '0;
    flush = 1'b0;
  endtask

  task automatic issue(input int p, input bit wr, input int dst, input int lat,
                       input logic [127:0] d);
    issue_valid[p] = 1'b1;
    issue_reg_wr[p] = wr;
    issue_dst[p*AW +: AW] = AW'(dst);
    issue_lat[p*LW +: LW] = LW'(lat);
    issue_data[p*DW +: DW] = d;
  endtask

  task automatic set_fwd(input int f, input int a);
    fwd_addr[f*AW +: AW] = AW'(a);
  endtask

  task automatic fwd_defaults();
    for (int f = 0; f < NF; f++) set_fwd(f, 100 + f);
  endtask

  initial begin
    logic [127:0] one4;
    one4 = {4{32'h1}};
    rst = 1'b0;
    issue_valid = '0; issue_reg_wr = '0; issue_dst = '0; issue_lat = '0; issue_data = '0;
    flush = 1'b0;
    fwd_defaults();
    model_clear();

    // Reset state
    #1;
    chk("rst_wb_en", wb_en, 0);
    chk("rst_lat_err", lat_err, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    compare_all();
    @(posedge clk);
    #3 rst = 1'b1;

    // 1: odd packet, full latency
    set_fwd(0, 3);
    issue(1, 1, 3, 7, one4);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c <= 6) chk($sformatf("t1_pend_c%0d", c), fwd_pending[0], 1);
      if (c == 7) begin
        chk("t1_hit", fwd_hit[0], 1);
        chk("t1_data", fwd_data[DW-1:0], one4);
        chk("t1_wb_en", wb_en, 2'b10);
        chk("t1_wb_addr", wb_addr[2*AW-1:AW], 3);
      end
      if (c == 8) chk("t1_wb_off", wb_en, 0);
    end

    // 2: younger not-ready match hides older ready one
    fwd_defaults();
    set_fwd(1, 1);
    issue(0, 1, 1, 2, 128'hAAAA);
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) issue(1, 1, 1, 6, 128'hBBBB);
      step();
      if (c <= 6) begin
        chk($sformatf("t2_pend_c%0d", c), fwd_pending[1], 1);
        chk($sformatf("t2_nohit_c%0d", c), fwd_hit[1], 0);
      end
      if (c == 7) begin
        chk("t2_hit", fwd_hit[1], 1);
        chk("t2_data", fwd_data[2*DW-1:DW], 128'hBBBB);
      end
    end

    // 3: same-stage tie goes to odd pipe
    fwd_defaults();
    set_fwd(2, 5);
    issue(0, 1, 5, 2, 128'h10);
    issue(1, 1, 5, 2, 128'h11);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) chk("t3_pend", fwd_pending[2], 1);
      if (c == 2) begin
        chk("t3_hit", fwd_hit[2], 1);
        chk("t3_data", fwd_data[3*DW-1:2*DW], 128'h11);
      end
      if (c == 7) chk("t3_wb_both", wb_en, 2'b11);
    end

    // 4: flush with stages 1-5 occupied and a same-cycle issue
    fwd_defaults();
    set_fwd(0, 12);
    set_fwd(1, 10);
    set_fwd(2, 20);
    for (int c = 1; c <= 5; c++) begin
      issue(0, 1, 9 + c, 1, 128'h100 + c);
      step();
    end
    issue(1, 1, 20, 1, 128'h200);
    flush = 1'b1;
    step();
    chk("t4_killed_hit", fwd_hit[0], 0);
    chk("t4_killed_pend", fwd_pending[0], 0);
    chk("t4_dropped_hit", fwd_hit[2], 0);
    chk("t4_survivor_hit", fwd_hit[1], 1);
    chk("t4_survivor_data", fwd_data[2*DW-1:DW], 128'h101);
`ifdef SPU_PIPE_STATS_EN
    chk("t4_flushed", stat_flushed, 4);
`endif
    step();
    chk("t4_wb1_en", wb_en, 2'b01);
    chk("t4_wb1_addr", wb_addr[AW-1:0], 10);
    step();
    chk("t4_wb2_addr", wb_addr[AW-1:0], 11);
    step();
    chk("t4_wb3_off", wb_en, 0);
    repeat (DEPTH) step();

    // 5: out-of-range latencies
    fwd_defaults();
    set_fwd(3, 30);
    set_fwd(4, 31);
    chk("t5_lat_err_pre", lat_err, 0);
    issue(0, 1, 30, 0, 128'h30);
    issue(1, 1, 31, 9, 128'h31);
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("t5_lat_err_c%0d", c), lat_err, 1);
      if (c == 1) begin
        chk("t5_lat0_hit", fwd_hit[3], 1);
        chk("t5_lat0_data", fwd_data[4*DW-1:3*DW], 128'h30);
      end
      if (c <= 6) chk($sformatf("t5_lat9_pend_c%0d", c), fwd_pending[4], 1);
      if (c == 7) begin
        chk("t5_lat9_hit", fwd_hit[4], 1);
        chk("t5_wb_both", wb_en, 2'b11);
      end
    end

    // 6: asynchronous reset with work in flight
    fwd_defaults();
    set_fwd(5, 40);
    for (int c = 1; c <= 5; c++) begin
      issue(0, 1, 39 + c, 1, 128'h400 + c);
      step();
    end
    chk("t6_pre_hit", fwd_hit[5], 1);
    #2 rst = 1'b0;
    #1;
    model_clear();
    chk("t6_rst_wb_en", wb_en, 0);
    chk("t6_rst_fwd_hit", fwd_hit, 0);
    chk("t6_rst_fwd_pend", fwd_pending, 0);
    chk("t6_rst_fwd_data", fwd_data[6*DW-1:5*DW], 0);
    chk("t6_rst_lat_err", lat_err, 0);
    chk("t6_rst_retired", stat_retired, 0);
    chk("t6_rst_flushed", stat_flushed, 0);
    compare_all();
    @(posedge clk);
    #1 compare_all();
    #2 rst = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("t6_no_retire_c%0d", c), wb_en, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
